// File: rtl/inverter_bist_ctrl.sv
// On-chip self-test sequencer for the NAND-only inverter: applies an alternating
// 1/0 pattern, waits a settle time per vector, and counts non-inverted outputs.
module inverter_bist_ctrl #(
  parameter int NUM_VECTORS   = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 4,
  parameter int IDX_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] vec_idx
);

  // The settle counter only needs to reach SETTLE_CYCLES-1.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             mismatch;

  // A healthy inverter never echoes its input.
  assign mismatch = (dut_out == dut_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dut_in     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      vec_idx    <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            err_count <= '0;
            vec_idx   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        DRIVE: begin
          dut_in     <= ~vec_idx[0];
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (mismatch && (err_count != ERR_MAX)) begin
            err_count <= err_count + 1'b1;
          end
          // The verdict must account for this final sample, hence the explicit mismatch term.
          if (vec_idx == IDX_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            vec_idx <= vec_idx + 1'b1;
            state   <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inverter_bist_ctrl.sv
// Directed self-checking bench for inverter_bist_ctrl: default, saturating and
// minimal-length configurations driven by small behavioural inverter models.
module tb_inverter_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic       dut_out_a, dut_out_b, dut_out_c;
  logic       dut_in_a, busy_a, done_a, pass_a;
  logic       dut_in_b, busy_b, done_b, pass_b;
  logic       dut_in_c, busy_c, done_c, pass_c;
  logic [3:0] err_a, idx_a, idx_b, err_c, idx_c;
  logic [1:0] err_b;
  int         mode = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // mode 0: ideal inverter, 1: output stuck at 0, 2: non-inverting buffer
  always_comb begin
    case (mode)
      1:       dut_out_a = 1'b0;
      2:       dut_out_a = dut_in_a;
      default: dut_out_a = ~dut_in_a;
    endcase
  end
  assign dut_out_b = dut_in_b;
  assign dut_out_c = ~dut_in_c;

  inverter_bist_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_out(dut_out_a), .dut_in(dut_in_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .vec_idx(idx_a)
  );

  inverter_bist_ctrl #(.ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_out(dut_out_b), .dut_in(dut_in_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .vec_idx(idx_b)
  );

  inverter_bist_ctrl #(.NUM_VECTORS(1), .SETTLE_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .dut_out(dut_out_c), .dut_in(dut_in_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .vec_idx(idx_c)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Starts a run on dut_a and returns the edge count from the start edge to done (0 on timeout).
  task automatic applyStimulus(input bit hold, output int edges);
    int k;
    edges = 0;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busy_after_start", int'(busy_a), 1);
    checkOutput("done_cleared", int'(done_a), 0);
    checkOutput("err_cleared", int'(err_a), 0);
    if (!hold) begin
      @(negedge clk) start_a = 1'b0;
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (((n - 1) % 6 == 0) && (n <= 25)) begin
        k = (n - 1) / 6;
        checkOutput($sformatf("dut_in_vec%0d", k), int'(dut_in_a), (k % 2 == 0) ? 1 : 0);
        checkOutput($sformatf("vec_idx_vec%0d", k), int'(idx_a), k);
      end
      if (done_a) begin
        edges = n;
        break;
      end
    end
  endtask

  initial begin
    int e;
    int eb;
    int ec;

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_dut_in", int'(dut_in_a), 0);
    checkOutput("rst_busy", int'(busy_a), 0);
    checkOutput("rst_done", int'(done_a), 0);
    checkOutput("rst_pass", int'(pass_a), 0);
    checkOutput("rst_err", int'(err_a), 0);
    checkOutput("rst_vec_idx", int'(idx_a), 0);
    @(negedge clk) rst = 1'b0;

    $display("[TB] ideal inverter run");
    mode = 0;
    applyStimulus(1'b0, e);
    checkOutput("ideal_done_edge", e, 30);
    checkOutput("ideal_pass", int'(pass_a), 1);
    checkOutput("ideal_err", int'(err_a), 0);
    checkOutput("ideal_busy", int'(busy_a), 0);
    checkOutput("ideal_vec_idx", int'(idx_a), 4);
    checkOutput("ideal_dut_in_hold", int'(dut_in_a), 1);

    $display("[TB] output stuck at 0");
    mode = 1;
    applyStimulus(1'b0, e);
    checkOutput("stuck_done_edge", e, 30);
    checkOutput("stuck_err", int'(err_a), 2);
    checkOutput("stuck_pass", int'(pass_a), 0);

    $display("[TB] start held through a run");
    applyStimulus(1'b1, e);
    checkOutput("hold_done_edge", e, 30);
    checkOutput("hold_err", int'(err_a), 2);
    @(posedge clk);
    #1;
    checkOutput("restart_done", int'(done_a), 0);
    checkOutput("restart_err", int'(err_a), 0);
    checkOutput("restart_busy", int'(busy_a), 1);
    @(negedge clk) start_a = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("restart_dut_in", int'(dut_in_a), 1);
    checkOutput("restart_vec_idx", int'(idx_a), 0);
    e = 0;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        e = n;
        break;
      end
    end
    checkOutput("restart_done_edge", e, 30);
    checkOutput("restart_final_err", int'(err_a), 2);

    $display("[TB] reset during settle of vector 2");
    mode = 0;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    @(negedge clk) start_a = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checkOutput("mid_vec_idx", int'(idx_a), 2);
    checkOutput("mid_busy", int'(busy_a), 1);
    checkOutput("mid_dut_in", int'(dut_in_a), 1);
    @(negedge clk) rst = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy_a), 0);
    checkOutput("abort_done", int'(done_a), 0);
    checkOutput("abort_dut_in", int'(dut_in_a), 0);
    checkOutput("abort_vec_idx", int'(idx_a), 0);
    checkOutput("abort_err", int'(err_a), 0);
    checkOutput("abort_pass", int'(pass_a), 0);
    @(negedge clk) rst = 1'b0;
    applyStimulus(1'b0, e);
    checkOutput("fresh_done_edge", e, 30);
    checkOutput("fresh_pass", int'(pass_a), 1);
    checkOutput("fresh_err", int'(err_a), 0);

    $display("[TB] saturating counter, non-inverting model");
    @(negedge clk) start_b = 1'b1;
    @(posedge clk);
    @(negedge clk) start_b = 1'b0;
    eb = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done_b) begin
        eb = n;
        break;
      end
    end
    checkOutput("sat_done_edge", eb, 30);
    checkOutput("sat_err", int'(err_b), 3);
    checkOutput("sat_pass", int'(pass_b), 0);

    $display("[TB] single vector, single settle cycle");
    @(negedge clk) start_c = 1'b1;
    @(posedge clk);
    @(negedge clk) start_c = 1'b0;
    ec = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done_c) begin
        ec = n;
        break;
      end
    end
    checkOutput("min_done_edge", ec, 3);
    checkOutput("min_pass", int'(pass_c), 1);
    checkOutput("min_err", int'(err_c), 0);
    checkOutput("min_dut_in", int'(dut_in_c), 1);
    checkOutput("min_busy", int'(busy_c), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inverter_bist_ctrl.md
Name: inverter_bist_ctrl

Overview:
Built-in self-test sequencer for the NAND-only synthesized inverter. On request it drives the inverter input with an alternating 1/0 pattern and waits a programmable settle time after each change. It then samples the inverter output, checks it is the complement of the input, and counts mismatches. It sits beside the inverter netlist and replaces bench-driven stimulus with an on-chip pass/fail result.

Parameters:
NUM_VECTORS, 5, number of vectors applied per run (>=1); vector k drives 1 for even k and 0 for odd k.
SETTLE_CYCLES, 4, clock cycles between driving a vector and sampling the output (>=1).
ERR_W, 4, width of the mismatch counter; the counter saturates at 2^ERR_W-1.
IDX_W, 4, width of the vector index; must satisfy 2^IDX_W >= NUM_VECTORS.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  run request; sampled only in IDLE or DONE.
dut_out  input  1  inverter output under test.
dut_in  output  1  registered drive to the inverter input.
busy  output  1  high while a run is in progress (DRIVE/SETTLE/CHECK).
done  output  1  high in DONE; held until the next run starts or reset.
pass  output  1  valid when done=1: high iff err_count==0.
err_count  output  ERR_W  number of mismatches in the current or last run.
vec_idx  output  IDX_W  index of the vector currently applied.

Behaviour:
- Reset (async, rst=1): state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, settle counter=0.
- All outputs are registered; no combinational path from dut_out to any output.
- IDLE: start=1 at an edge -> DRIVE; same edge clears err_count, vec_idx, done and pass, and sets busy=1.
- DRIVE, one cycle: the edge loads dut_in = ~vec_idx[0] (vector 0 drives 1) and clears the settle counter -> SETTLE.
- SETTLE: each edge increments the settle counter.
  - At the edge where counter==SETTLE_CYCLES-1 -> CHECK.
  - Exactly SETTLE_CYCLES edges are spent in SETTLE.
- CHECK, one cycle: the edge samples dut_out.
  - If dut_out == dut_in (i.e. not inverted), err_count increments unless it is already all-ones (saturating).
  - If vec_idx==NUM_VECTORS-1 -> DONE. Otherwise vec_idx increments -> DRIVE.
- DONE: busy=0, done=1, pass=(final err_count==0).
  - dut_in, err_count and vec_idx hold.
  - start=1 at an edge restarts exactly as from IDLE (-> DRIVE, counters cleared, done=0).
- Timing:
  - Each vector costs SETTLE_CYCLES+2 cycles.
  - done rises at the edge NUM_VECTORS*(SETTLE_CYCLES+2) edges after the edge that sampled start.
  - busy falls on that same edge.
  - Defaults: 30 edges.
- start while busy=1 is ignored; no queuing.
- rst asserted mid-run aborts immediately to reset values; no partial result is retained.
- vec_idx never wraps within a run; the index stops at NUM_VECTORS-1.

Test Plan:
- Ideal inverter model (dut_out=~dut_in), defaults, pulse start -> dut_in sequence 1,0,1,0,1; done high 30 edges after the start edge; pass=1, err_count=0, busy low in DONE.
- dut_out stuck at 0 -> mismatches on vectors 1 and 3 (dut_in=0); err_count=2, pass=0.
- Non-inverting model (dut_out=dut_in), ERR_W=2 -> 5 mismatches saturate; err_count=3, pass=0.
- Hold start=1 throughout a run -> no restart while busy; after DONE the next edge with start=1 clears done and err_count and begins a new run with dut_in=1.
- Assert rst during SETTLE of vector 2 -> all outputs return to reset values asynchronously; a fresh start gives a clean full run with pass=1.
- SETTLE_CYCLES=1, NUM_VECTORS=1, ideal model -> done 3 edges after the start edge; pass=1.
